// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin write arbiter feeding one shared WIDTH-bit register.
// Define ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module dff_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rest,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    din,
  output logic [NREQ-1:0]          gnt,
  output logic                     done,
  output logic [WIDTH-1:0]         q,
  output logic                     valid,
  output logic [$clog2(NREQ)-1:0]  last_id
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, GNT, CAP} state_t;
  state_t            r_state, w_state;
  logic [NREQ-1:0]   r_gnt, w_gnt;
  logic              r_done, w_done, r_valid, w_valid;
  logic [WIDTH-1:0]  r_q, w_q;
  logic [IW-1:0]     r_last_id, w_last_id, r_w, w_w, w_win;
`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    w_win = '0;
    for (int k = NREQ-1; k >= 0; k--)
      if (req[k]) w_win = IW'(k);
  end
`else
  logic [IW-1:0]     r_rr, w_rr, w_idx;
  // descending scan so the smallest offset from rr+1 is assigned last and wins
  always_comb begin
    w_win = '0;
    w_idx = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      w_idx = IW'((int'(r_rr) + 1 + k) % NREQ);
      if (req[w_idx]) w_win = w_idx;
    end
  end
`endif
  always_comb begin
    w_state   = r_state;
    w_gnt     = '0;
    w_done    = 1'b0;
    w_q       = r_q;
    w_valid   = r_valid;
    w_last_id = r_last_id;
    w_w       = r_w;
`ifndef ARB_FIXED_PRIO_EN
    w_rr      = r_rr;
`endif
    case (r_state)
      IDLE: if (|req) begin
        w_gnt   = NREQ'(1) << w_win;
        w_w     = w_win;
        w_state = GNT;
      end
      GNT: if (req[r_w]) begin
        w_q       = din[r_w*WIDTH +: WIDTH];
        w_valid   = 1'b1;
        w_last_id = r_w;
        w_done    = 1'b1;
        w_state   = CAP;
`ifndef ARB_FIXED_PRIO_EN
        w_rr      = r_w;
`endif
      end else w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rest) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_done    <= 1'b0;
      r_q       <= '0;
      r_valid   <= 1'b0;
      r_last_id <= '0;
      r_w       <= '0;
`ifndef ARB_FIXED_PRIO_EN
      r_rr      <= IW'(NREQ-1);
`endif
    end else begin
      r_state   <= w_state;
      r_gnt     <= w_gnt;
      r_done    <= w_done;
      r_q       <= w_q;
      r_valid   <= w_valid;
      r_last_id <= w_last_id;
      r_w       <= w_w;
`ifndef ARB_FIXED_PRIO_EN
      r_rr      <= w_rr;
`endif
    end
  end
  assign gnt     = r_gnt;
  assign done    = r_done;
  assign q       = r_q;
  assign valid   = r_valid;
  assign last_id = r_last_id;
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb_dff_bank_arbiter: directed and random stimulus against a transfer-level reference model.
module tb_dff_bank_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic             clk = 1'b0;
  logic             rest = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   din = '0;
  logic [N-1:0]     gnt;
  logic             done, valid;
  logic [W-1:0]     q;
  logic [1:0]       last_id;
  int n_pass = 0, n_total = 0;
  dff_bank_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clk(clk), .rest(rest), .req(req), .din(din), .gnt(gnt),
    .done(done), .q(q), .valid(valid), .last_id(last_id)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask
  function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (r[k]) return k;
`else
    for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
`endif
    return 0;
  endfunction
  // model phase: 0 waiting for requests, 1 grant issued, 2 write completed
  int m_ph = 0, m_win = 0, m_rr = N-1, m_last = 0;
  logic [N-1:0] m_gnt = '0;
  logic         m_done = 1'b0, m_valid = 1'b0;
  logic [W-1:0] m_q = '0;
  always @(posedge clk) begin
    if (rest) begin
      m_ph <= 0; m_gnt <= '0; m_done <= 1'b0; m_q <= '0; m_valid <= 1'b0; m_last <= 0; m_rr <= N-1;
    end else if (m_ph == 0) begin
      m_done <= 1'b0;
      if (req != 0) begin
        m_win <= pick(req, m_rr);
        m_gnt <= N'(1) << pick(req, m_rr);
        m_ph  <= 1;
      end
    end else if (m_ph == 1) begin
      m_gnt <= '0;
      if (req[m_win]) begin
        m_q <= din[m_win*W +: W]; m_valid <= 1'b1; m_last <= m_win; m_rr <= m_win; m_done <= 1'b1; m_ph <= 2;
      end else m_ph <= 0;
    end else begin
      m_done <= 1'b0; m_ph <= 0;
    end
  end
  always @(negedge clk) begin
    chk("model_gnt", 32'(gnt), 32'(m_gnt));
    chk("model_done", 32'(done), 32'(m_done));
    chk("model_q", 32'(q), 32'(m_q));
    chk("model_valid", 32'(valid), 32'(m_valid));
    chk("model_last_id", 32'(last_id), 32'(m_last));
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("gnt_done_excl", 32'(|gnt && done), 32'd0);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < N; i++) din[i*W +: W] = W'(8'h10 + i);
    req = 4'b1111;
    step(); step();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rest = 1'b0;
    for (int i = 0; i < N; i++) begin
      step();
`ifdef ARB_FIXED_PRIO_EN
      chk("rot_gnt", 32'(gnt), 32'h1);
      step();
      chk("rot_q", 32'(q), 32'h10);
`else
      chk("rot_gnt", 32'(gnt), 32'(1 << i));
      step();
      chk("rot_q", 32'(q), 32'h10 + i);
`endif
      chk("rot_done", 32'(done), 32'h1);
      step();
      chk("rot_done_clr", 32'(done), 32'h0);
    end
    req = 4'b1001;
    step();
    chk("wrap_gnt", 32'(gnt), 32'h1);
    step(); step();
    req = 4'b0000;
    step();
    din[2*W +: W] = 8'hA5;
    req = 4'b0100;
    step();
    chk("single_gnt", 32'(gnt), 32'h4);
    step();
    chk("single_q", 32'(q), 32'hA5);
    chk("single_last", 32'(last_id), 32'h2);
    chk("single_valid", 32'(valid), 32'h1);
    chk("single_done", 32'(done), 32'h1);
    req = 4'b0000;
    step();
    chk("single_done_clr", 32'(done), 32'h0);
    req = 4'b0010;
    step();
    chk("abort_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    step();
    chk("abort_gnt_clr", 32'(gnt), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_q", 32'(q), 32'hA5);
    step();
    req = 4'b0010;
    step();
    chk("abort_regrant", 32'(gnt), 32'h2);
    step();
    chk("abort_q2", 32'(q), 32'h11);
    req = 4'b0000;
    step();
    din[0 +: W] = 8'h3C;
    req = 4'b0001;
    step();
    chk("midrst_gnt", 32'(gnt), 32'h1);
    rest = 1'b1;
    step();
    chk("midrst_q", 32'(q), 32'h00);
    chk("midrst_gnt0", 32'(gnt), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    rest = 1'b0;
    req = 4'b0000;
    step();
    chk("midrst_idle", 32'(done | |gnt), 32'h0);
    for (int c = 0; c < 3000; c++) begin
      rest = ($urandom_range(0, 59) == 0);
      req  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      din  = $urandom;
      step();
    end
    rest = 1'b0; req = '0;
    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
